dot_accumulator: RTL and testbench

Downstream consumer of the signed 8-bit multiplier in the matrix coprocessor datapath. It sums a fixed-length stream of signed products into one result-matrix element (row·column dot product) with two's-complement overflow tracking. It presents the finished element through a valid/ready handshake to the result write-back logic. Overflow is sticky per element: it merges the multiplier's per-product overflow flag with the accumulator's own addition overflow.

---
 rtl/dot_accumulator.sv | 99 +++++++++
 tb/tb_dot_accumulator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dot_accumulator.sv
// Signed dot-product accumulator: sums LEN products into one result element and tracks overflow.
// Build option: define SATURATE_EN to clamp on addition overflow instead of wrapping.
module dot_accumulator #(
  parameter int DW  = 8,
  parameter int LEN = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] prod,
  input  logic                 prod_ovf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] sum,
  output logic                 ovf,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [7:0]          LAST = 8'(LEN - 1);
  localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  state_t                state_reg, state_next;
  logic signed [DW-1:0]  acc_reg, acc_next;
  logic                  ovf_reg, ovf_next;
  logic [7:0]            cnt_reg, cnt_next;
  logic [DW:0]           add_wide;
  logic                  add_ovf;
  logic signed [DW-1:0]  add_res;

  // Sign-extended add; overflow when like-signed operands yield a differently signed result.
  always_comb begin
    add_wide = {acc_reg[DW-1], acc_reg} + {prod[DW-1], prod};
    add_ovf  = (acc_reg[DW-1] == prod[DW-1]) && (add_wide[DW-1] != acc_reg[DW-1]);
`ifdef SATURATE_EN
    add_res  = add_ovf ? (acc_reg[DW-1] ? SMIN : SMAX) : add_wide[DW-1:0];
`else
    add_res  = add_wide[DW-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      ovf_reg   <= ovf_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    ovf_next   = ovf_reg;
    cnt_next   = cnt_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = ACC;
          acc_next   = '0;
          ovf_next   = 1'b0;
          cnt_next   = '0;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_next = add_res;
          ovf_next = ovf_reg | prod_ovf | add_ovf;
          cnt_next = cnt_reg + 8'd1;
          if (cnt_reg == LAST) state_next = DONE;
        end
      end
      DONE: begin
        // Result held until consumed; start is deliberately not looked at here.
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign sum = acc_reg;
  assign ovf = ovf_reg;

endmodule

// File: tb/tb_dot_accumulator.sv
// Randomized and directed bench for dot_accumulator with an arithmetic reference model.
module tb_dot_accumulator;

  localparam int DW  = 8;
  localparam int LEN = 5;
`ifdef SATURATE_EN
  localparam int E_BIG = 27;
  localparam int E_NEG = -128;
`else
  localparam int E_BIG = 100;
  localparam int E_NEG = 127;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] prod;
  logic                 prod_ovf;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] sum;
  logic                 ovf;
  logic                 busy;

  dot_accumulator #(.DW(DW), .LEN(LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .prod(prod), .prod_ovf(prod_ovf), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int s; bit o;} exp_t;
  exp_t exp_q[$];

  logic signed [DW-1:0] terms [0:LEN-1];
  logic                 tovf  [0:LEN-1];
  int passed = 0;
  int total  = 0;
  int elem   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // Reference: exact integer sum per step, then wrap or clamp into DW-bit range.
  task automatic model(output int s, output bit o);
    int a;
    int t;
    a = 0;
    o = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      t = a + int'(terms[i]);
      if (tovf[i]) o = 1'b1;
      if (t > 127 || t < -128) begin
        o = 1'b1;
`ifdef SATURATE_EN
        t = (t > 127) ? 127 : -128;
`else
        t = (t > 127) ? t - 256 : t + 256;
`endif
      end
      a = t;
    end
    s = a;
  endtask

  task automatic set_terms(input int t0, input int t1, input int t2, input int t3, input int t4);
    terms[0] = DW'(t0); terms[1] = DW'(t1); terms[2] = DW'(t2);
    terms[3] = DW'(t3); terms[4] = DW'(t4);
    for (int i = 0; i < LEN; i++) tovf[i] = 1'b0;
  endtask

  // Runs one element; optional stall before term gap_at, and hold cycles with out_ready low.
  task automatic run_elem(input int gap_at, input int gap_len, input int hold,
                          input bit lit, input int lit_s, input bit lit_o);
    exp_t e;
    model(e.s, e.o);
    exp_q.push_back(e);
    start = 1'b1; in_valid = 1'b1; prod = DW'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          in_valid = 1'b0; prod = DW'($urandom); start = (g == 0);
          @(negedge clk);
          chk("stall_in_ready", in_ready, 1);
          chk("stall_no_valid", out_valid, 0);
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
      in_valid = 1'b1; prod = terms[i]; prod_ovf = tovf[i];
      @(negedge clk);
      chk("acc_in_ready", in_ready, 1);
      chk("acc_no_early_valid", out_valid, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; prod_ovf = 1'b0;
    @(negedge clk);
    chk("latency_out_valid", out_valid, 1);
    if (lit) begin
      chk("literal_sum", int'(sum), lit_s);
      chk("literal_ovf", ovf, lit_o);
    end
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0; in_valid = 1'b1; prod = DW'($urandom); prod_ovf = 1'b1; start = 1'b1;
      @(negedge clk);
      chk("done_in_ready", in_ready, 0);
      chk("done_held_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; start = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; start = 1'b0; in_valid = 1'b0; prod_ovf = 1'b0;
    @(negedge clk);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 0);
  endtask

  // Compare process: DUT result against the model whenever out_valid is high.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_decode", busy, int'(in_ready | out_valid));
      if (out_valid) begin
        chk("pending_elements", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          chk("model_sum", int'(sum), exp_q[0].s);
          chk("model_ovf", ovf, exp_q[0].o);
          if (out_ready) begin
            $display("elem %0d: sum=%0d ovf=%0d (model %0d/%0d)",
                     elem, sum, ovf, exp_q[0].s, exp_q[0].o);
            void'(exp_q.pop_front());
            elem++;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; prod = '0; prod_ovf = 1'b0; out_ready = 1'b0;
    #2;
    chk("reset_sum", int'(sum), 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_busy", busy, 0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    set_terms(1, 2, 3, 4, 5);            run_elem(-1, 0, 0, 1, 15, 0);
    set_terms(100, 100, -100, 0, 0);     run_elem(-1, 0, 0, 1, E_BIG, 1);
    set_terms(-64, -64, -1, 0, 0);       run_elem(-1, 0, 0, 1, E_NEG, 1);
    set_terms(1, 1, 1, 1, 1); tovf[1] = 1'b1;
                                         run_elem(-1, 0, 0, 1, 5, 1);
    set_terms(1, 2, 3, 4, 5);            run_elem(2, 2, 0, 1, 15, 0);
    set_terms(1, 2, 3, 4, 5);            run_elem(-1, 0, 3, 1, 15, 0);

    // Reset after three accepted terms, asserted between clock edges.
    set_terms(7, 7, 7, 7, 7);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; prod = terms[i];
      @(posedge clk); #1;
    end
    #3;
    exp_q.delete();
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("midrst_sum", int'(sum), 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    @(negedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    set_terms(2, 2, 2, 2, 2);            run_elem(-1, 0, 0, 1, 10, 0);

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < LEN; i++) begin
        terms[i] = DW'($urandom_range(0, 255));
        tovf[i]  = ($urandom_range(0, 9) == 0);
      end
      run_elem($urandom_range(0, LEN - 1), $urandom_range(0, 2), $urandom_range(0, 3), 0, 0, 0);
    end

    chk("all_elements_consumed", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
